// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered WIDTH-bit ALU with flags, shifts and iterative multiplier
//
// Optional feature macro: ALU_MUL_EN
//   defined   : opcode 1010 runs an unsigned shift-add multiply over WIDTH cycles
//   undefined : no multiplier hardware; 1010 is an illegal opcode and busy is tied low
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             operation request, taken only while busy=0
//   A, B, opcode      operands and operation, captured on the accepting edge
//   Result            registered result, held until the next completion
//   carry             carry / borrow / shift-out / multiply-high-nonzero
//   zero, negative    derived from Result
//   overflow          signed overflow for ADD/SUB/INC/DEC
//   err               illegal opcode on the last completion
//   busy              multiply in progress
//   done              one-cycle completion pulse
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       opcode,
    output logic [WIDTH-1:0] Result,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             overflow,
    output logic             err,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_INC = 4'b0110;
    localparam logic [3:0] OP_DEC = 4'b0111;
    localparam logic [3:0] OP_SHL = 4'b1000;
    localparam logic [3:0] OP_SHR = 4'b1001;

    // Single-cycle datapath: bit WIDTH of 'wide' is the carry, low bits the result.
    logic [WIDTH:0]   wide;
    logic             ovf_n;
    logic             err_n;
    logic             accept_single;

    always_comb begin
        wide  = '0;
        ovf_n = 1'b0;
        err_n = 1'b0;
        case (opcode)
            OP_ADD: begin
                wide  = {1'b0, A} + {1'b0, B};
                ovf_n = (A[WIDTH-1] == B[WIDTH-1]) && (wide[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                wide  = {1'b0, A} - {1'b0, B};
                ovf_n = (A[WIDTH-1] != B[WIDTH-1]) && (wide[WIDTH-1] != A[WIDTH-1]);
            end
            OP_INC: begin
                wide  = {1'b0, A} + (WIDTH+1)'(1);
                ovf_n = !A[WIDTH-1] && wide[WIDTH-1];
            end
            OP_DEC: begin
                wide  = {1'b0, A} - (WIDTH+1)'(1);
                ovf_n = A[WIDTH-1] && !wide[WIDTH-1];
            end
            OP_AND: wide = {1'b0, A & B};
            OP_OR:  wide = {1'b0, A | B};
            OP_XOR: wide = {1'b0, A ^ B};
            OP_NOT: wide = {1'b0, ~A};
            OP_SHL: wide = {A, 1'b0};
            // The shifted-out LSB lands in the carry position.
            OP_SHR: wide = {A[0], 1'b0, A[WIDTH-1:1]};
            default: err_n = 1'b1;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1010;
    localparam int         CW     = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {S_IDLE, S_MUL} state_t;
    state_t state_q, state_n;

    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] a_sh;
    logic [2*WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0]   b_sh;
    logic               accept_mul;
    logic               mul_fin;

    assign accept_mul    = start && (state_q == S_IDLE) && (opcode == OP_MUL);
    assign accept_single = start && (state_q == S_IDLE) && (opcode != OP_MUL);
    assign busy          = (state_q == S_MUL);
    // The last partial product is folded in combinationally so the product
    // is registered straight into Result on the final edge.
    assign acc_nx        = b_sh[0] ? (acc + a_sh) : acc;
    assign mul_fin       = busy && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            S_IDLE:  if (accept_mul) state_n = S_MUL;
            S_MUL:   if (count == LAST) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            count <= '0;
        end else if (accept_mul) begin
            acc   <= '0;
            a_sh  <= {{WIDTH{1'b0}}, A};
            b_sh  <= B;
            count <= '0;
        end else if (busy) begin
            acc   <= acc_nx;
            a_sh  <= a_sh << 1;
            b_sh  <= b_sh >> 1;
            count <= count + CW'(1);
        end
    end
`else
    assign accept_single = start;
    assign busy          = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            err      <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept_single) begin
                Result   <= wide[WIDTH-1:0];
                carry    <= wide[WIDTH];
                overflow <= ovf_n;
                err      <= err_n;
                done     <= 1'b1;
            end
`ifdef ALU_MUL_EN
            else if (mul_fin) begin
                Result   <= acc_nx[WIDTH-1:0];
                carry    <= |acc_nx[2*WIDTH-1:WIDTH];
                overflow <= 1'b0;
                err      <= 1'b0;
                done     <= 1'b1;
            end
`endif
        end
    end

    assign zero     = (Result == '0);
    assign negative = Result[WIDTH-1];

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq (WIDTH=8)
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [3:0]   opcode = '0;
    logic [W-1:0] Result;
    logic         carry, zero, negative, overflow, err, busy, done;

    int n_tests = 0;
    int n_fail  = 0;
    int dones;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .opcode(opcode),
        .Result(Result), .carry(carry), .zero(zero), .negative(negative),
        .overflow(overflow), .err(err), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request for one edge, then sample #1 after that edge.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        opcode = op; A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".Result"}, Result, 0);
        check({tag, ".carry"}, carry, 0);
        check({tag, ".zero"}, zero, 1);
        check({tag, ".negative"}, negative, 0);
        check({tag, ".overflow"}, overflow, 0);
        check({tag, ".err"}, err, 0);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".done"}, done, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("rst");
        rst = 1'b0;
        tick();

        // ADD 0xFF + 0x01
        issue(4'b0000, 8'hFF, 8'h01);
        check("add.Result", Result, 8'h00);
        check("add.carry", carry, 1);
        check("add.zero", zero, 1);
        check("add.ovf", overflow, 0);
        check("add.done", done, 1);
        tick();
        check("add.done_fall", done, 0);
        check("add.hold", Result, 8'h00);

        // SUB 0x80 - 0x01
        issue(4'b0001, 8'h80, 8'h01);
        check("sub.Result", Result, 8'h7F);
        check("sub.carry", carry, 0);
        check("sub.ovf", overflow, 1);
        check("sub.neg", negative, 0);

        // DEC 0x00
        issue(4'b0111, 8'h00, 8'h00);
        check("dec.Result", Result, 8'hFF);
        check("dec.carry", carry, 1);
        check("dec.neg", negative, 1);
        check("dec.ovf", overflow, 0);

        // Back-to-back single-cycle ops, start held high across two edges
        opcode = 4'b0100; A = 8'hF0; B = 8'h3C; start = 1'b1;
        @(posedge clk); #1;
        check("xor.Result", Result, 8'hCC);
        check("xor.done", done, 1);
        opcode = 4'b0010;
        @(posedge clk); #1;
        start = 1'b0;
        check("and.Result", Result, 8'h30);
        check("and.done", done, 1);

        // Shifts and INC
        issue(4'b1000, 8'h81, 8'h00);
        check("shl.Result", Result, 8'h02);
        check("shl.carry", carry, 1);
        issue(4'b1001, 8'h81, 8'h00);
        check("shr.Result", Result, 8'h40);
        check("shr.carry", carry, 1);
        issue(4'b0110, 8'h7F, 8'h00);
        check("inc.Result", Result, 8'h80);
        check("inc.ovf", overflow, 1);
        check("inc.carry", carry, 0);
        issue(4'b0101, 8'h0F, 8'h00);
        check("not.Result", Result, 8'hF0);

        // Illegal opcode 1111, then a legal op clears err
        issue(4'b1111, 8'h12, 8'h34);
        check("ill.Result", Result, 0);
        check("ill.err", err, 1);
        check("ill.zero", zero, 1);
        check("ill.done", done, 1);
        issue(4'b0011, 8'h0A, 8'h50);
        check("or.Result", Result, 8'h5A);
        check("or.err", err, 0);

`ifdef ALU_MUL_EN
        // MUL 0x0F * 0x11 = 0x00FF
        issue(4'b1010, 8'h0F, 8'h11);
        check("mul1.busy0", busy, 1);
        check("mul1.done0", done, 0);
        dones = 0;
        for (int i = 1; i < W; i++) begin
            tick();
            if (busy !== 1'b1 || done !== 1'b0) dones++;
        end
        check("mul1.busy_window", dones, 0);
        tick();
        check("mul1.busy_end", busy, 0);
        check("mul1.done", done, 1);
        check("mul1.Result", Result, 8'hFF);
        check("mul1.carry", carry, 0);
        check("mul1.err", err, 0);

        // MUL 0x10 * 0x10 = 0x0100
        issue(4'b1010, 8'h10, 8'h10);
        repeat (W) tick();
        check("mul2.done", done, 1);
        check("mul2.Result", Result, 8'h00);
        check("mul2.carry", carry, 1);
        check("mul2.zero", zero, 1);

        // ADD start 3 cycles into a MUL is ignored: 0x03 * 0x05 = 0x0F
        issue(4'b1010, 8'h03, 8'h05);
        dones = 0;
        tick();
        tick();
        issue(4'b0000, 8'h01, 8'h01);
        for (int i = 0; i < 10; i++) begin
            if (done === 1'b1) dones++;
            tick();
        end
        check("ign.dones", dones, 1);
        check("ign.Result", Result, 8'h0F);
        check("ign.carry", carry, 0);

        // Reset 4 cycles into a MUL
        issue(4'b1010, 8'hFF, 8'hFF);
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        check_reset_values("rstmul");
        @(posedge clk); #1;
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) dones++;
        end
        check("rstmul.quiet", dones, 0);
`else
        // 1010 is illegal without the multiplier
        issue(4'b1010, 8'h03, 8'h05);
        check("mul_ill.Result", Result, 0);
        check("mul_ill.err", err, 1);
        check("mul_ill.zero", zero, 1);
        check("mul_ill.done", done, 1);
        check("mul_ill.busy", busy, 0);
        tick();
        check("mul_ill.busy2", busy, 0);

        // Asynchronous reset between edges returns outputs to reset values
        issue(4'b0011, 8'h0A, 8'h50);
        #2 rst = 1'b1;
        #1;
        check_reset_values("rstmid");
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
`endif

        issue(4'b0000, 8'h02, 8'h03);
        check("add2.Result", Result, 8'h05);
        check("add2.err", err, 0);
        check("add2.done", done, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the 4-bit combinational ALU. It extends the datapath to WIDTH bits and adds overflow and negative flags, shift operations and an iterative shift-add multiplier. Operations use a start/busy/done handshake. It sits between the operand register file and the writeback stage; results and flags are held stable until the next operation completes.

## Interface
- WIDTH, 8: operand/result width in bits; legal range ≥ 2.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; sampled only when busy=0.
- A  in  WIDTH  operand A, captured on an accepted start.
- B  in  WIDTH  operand B, captured on an accepted start.
- opcode  in  4  operation select, captured on an accepted start.
- Result  out  WIDTH  registered result.
- carry  out  1  carry/borrow/shift-out/multiply-high flag.
- zero  out  1  Result == 0.
- negative  out  1  Result[WIDTH-1].
- overflow  out  1  signed overflow.
- err  out  1  illegal opcode flag.
- busy  out  1  multi-cycle operation in progress.
- done  out  1  one-cycle completion pulse.

## Operation
- Opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOT A, 0110 INC A, 0111 DEC A, 1000 SHL A, 1001 SHR A (logical), 1010 MUL. All other opcodes are illegal.
- ADD/INC: {carry, Result} = WIDTH+1-bit sum.
- SUB/DEC: {carry, Result} = WIDTH+1-bit difference, so carry=1 means borrow (A<B for SUB, A==0 for DEC).
- overflow for ADD/SUB/INC/DEC: signed two's-complement overflow. overflow=0 for all other ops.
- AND/OR/XOR/NOT: carry=0.
- SHL: carry=A[WIDTH-1], Result={A[WIDTH-2:0],0}.
- SHR: carry=A[0], Result={0,A[WIDTH-1:1]}.
- MUL: unsigned shift-add, one partial product per cycle into a 2·WIDTH accumulator.
  - Result = low WIDTH bits.
  - carry = 1 if the high WIDTH bits are nonzero.
- Illegal opcode: Result=0, carry=0, overflow=0, zero=1, negative=0, err=1, single-cycle.
- err=0 on every legal completion.
- zero and negative are always derived from the new Result.
- States:
  - IDLE: start=1 with a single-cycle op → outputs update, done=1, stay in IDLE. start=1 with MUL → MUL, count=0.
  - MUL: count increments each cycle. When count reaches WIDTH-1 → outputs update, done=1, return to IDLE.
- start while busy=1 is ignored; no queuing.
- Outputs and flags hold their values between completions. Operand inputs are don't-care except on the accepting edge.

## Timing
- Reset values: Result=0, carry=0, zero=1, negative=0, overflow=0, err=0, busy=0, done=0, state=IDLE, accumulator=0, count=0.
- Single-cycle ops: start accepted at edge k → Result, flags and done=1 valid after edge k (latency 1). done falls after edge k+1.
- MUL: start accepted at edge k → busy=1 after edge k. At edge k+WIDTH, busy=0, done=1 and Result/flags update (latency WIDTH).
- Back-to-back: start may be asserted in the same cycle done=1, since busy=0 then. Single-cycle ops can therefore issue every cycle, each producing a done pulse.
- Reset asserted mid-MUL: immediate return to reset values. No done pulse; the operation is lost.
- count width = $clog2(WIDTH).

## Configuration
- ALU_MUL_EN defined: MUL (1010) implemented as described.
- ALU_MUL_EN undefined:
  - Multiplier datapath, counter and MUL state are not compiled.
  - 1010 is treated as an illegal opcode (err=1, latency 1).
  - busy is tied to 0.

## Test plan
- WIDTH=8, ADD A=0xFF B=0x01 → after 1 edge: Result=0x00, carry=1, zero=1, overflow=0, done pulse of 1 cycle.
- SUB A=0x80 B=0x01 → Result=0x7F, carry=0, overflow=1, negative=0. DEC A=0x00 → Result=0xFF, carry=1, negative=1.
- MUL (ALU_MUL_EN) A=0x0F B=0x11:
  - busy high for 8 cycles, done at edge 8 → Result=0xFF, carry=0.
  - A=0x10 B=0x10 → Result=0x00, carry=1, zero=1.
- start with ADD asserted 3 cycles into a MUL → ignored. MUL result is unchanged and there is exactly one done pulse.
- rst pulsed 4 cycles into a MUL → all outputs return to reset values immediately, with no done. A following ADD 0x02+0x03 → Result=0x05.
- opcode 1111, and 1010 without ALU_MUL_EN → Result=0, err=1, zero=1, done after 1 edge. The next legal op clears err.
